// File: rtl/tcp_resp_pkg.sv
// Shared types and widths for the TCP control-channel responder.
// Stats counters are built only when TCP_RESP_STATS_EN is defined.
package tcp_resp_pkg;

  localparam int LISTEN_W     = 16;
  localparam int OPEN_W       = 48;
  localparam int CLOSE_W      = 16;
  localparam int LISTEN_STS_W = 8;
  localparam int OPEN_STS_W   = 24;
  localparam int SID_W        = 16;
  localparam int CNT_W        = 16;
  localparam int STAT_W       = 32;

  typedef enum logic [2:0] {
    IDLE,
    LISTEN_RSP,
    OPEN_WAIT,
    OPEN_RSP,
    CLOSE
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [15:0] port;
  } session_entry_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] port;
  } listen_entry_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcp_resp_free_enc.sv
// Lowest-free-index priority encoder over a table's in-use bits.
// found is low when every entry is occupied.
module tcp_resp_free_enc
  import tcp_resp_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  used,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!used[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/tcp_conn_responder.sv
// Host TCP control-channel responder: listen table, session table, emulated handshake.
// Define TCP_RESP_STATS_EN to build the opens_ok/opens_fail/closes counters on stat_reg.
module tcp_conn_responder
  import tcp_resp_pkg::*;
#(
  parameter int MAX_LISTEN   = 8,
  parameter int MAX_SESSIONS = 16,
  parameter int OPEN_LATENCY = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axis_listen_port_tvalid,
  output logic                    s_axis_listen_port_tready,
  input  logic [LISTEN_W-1:0]     s_axis_listen_port_tdata,
  output logic                    m_axis_listen_port_status_tvalid,
  input  logic                    m_axis_listen_port_status_tready,
  output logic [LISTEN_STS_W-1:0] m_axis_listen_port_status_tdata,
  input  logic                    s_axis_open_connection_tvalid,
  output logic                    s_axis_open_connection_tready,
  input  logic [OPEN_W-1:0]       s_axis_open_connection_tdata,
  output logic                    m_axis_open_status_tvalid,
  input  logic                    m_axis_open_status_tready,
  output logic [OPEN_STS_W-1:0]   m_axis_open_status_tdata,
  input  logic                    s_axis_close_connection_tvalid,
  output logic                    s_axis_close_connection_tready,
  input  logic [CLOSE_W-1:0]      s_axis_close_connection_tdata,
  output logic [CNT_W-1:0]        active_sessions,
  output logic [CNT_W-1:0]        listen_count,
  output logic                    close_err,
  output logic [3*STAT_W-1:0]     stat_reg
);

  localparam int LIW = idx_w(MAX_LISTEN);
  localparam int SIW = idx_w(MAX_SESSIONS);

  state_t state_q, state_d;

  listen_entry_t  ltab [MAX_LISTEN];
  session_entry_t stab [MAX_SESSIONS];

  logic [MAX_LISTEN-1:0]   l_used;
  logic [MAX_SESSIONS-1:0] s_used;
  logic                    l_hit;
  logic                    l_found;
  logic [LIW-1:0]          l_idx;
  logic                    s_found;
  logic [SIW-1:0]          s_idx;

  logic sel_c, sel_l, sel_o;
  logic l_ok, l_ins, o_ok, c_in, c_ok;

  logic [LISTEN_W-1:0] lp;
  logic [31:0]         o_ip;
  logic [15:0]         o_port;

  logic [LISTEN_STS_W-1:0] lsts_q;
  logic [OPEN_STS_W-1:0]   osts_q;
  logic [CLOSE_W-1:0]      cid_q;
  logic [31:0]             wait_q;
  logic [CNT_W-1:0]        act_q;
  logic [CNT_W-1:0]        lcnt_q;
  logic                    err_q;

  assign lp     = s_axis_listen_port_tdata;
  assign o_ip   = s_axis_open_connection_tdata[31:0];
  assign o_port = s_axis_open_connection_tdata[47:32];

  always_comb begin
    l_used = '0;
    l_hit  = 1'b0;
    for (int i = 0; i < MAX_LISTEN; i++) begin
      l_used[i] = ltab[i].valid;
      if (ltab[i].valid && ltab[i].port == lp) l_hit = 1'b1;
    end
  end

  always_comb begin
    s_used = '0;
    for (int i = 0; i < MAX_SESSIONS; i++) begin
      s_used[i] = stab[i].valid;
    end
  end

  tcp_resp_free_enc #(.N(MAX_LISTEN), .IW(LIW)) u_listen_enc (
    .used  (l_used),
    .found (l_found),
    .idx   (l_idx)
  );

  tcp_resp_free_enc #(.N(MAX_SESSIONS), .IW(SIW)) u_sess_enc (
    .used  (s_used),
    .found (s_found),
    .idx   (s_idx)
  );

  // Re-listening an existing port succeeds without consuming an entry.
  assign l_ok  = (lp != '0) && (l_hit || l_found);
  assign l_ins = (lp != '0) && !l_hit && l_found;
  assign o_ok  = (o_ip != '0) && (o_port != '0) && s_found;
  assign c_in  = cid_q < CLOSE_W'(MAX_SESSIONS);
  assign c_ok  = c_in && s_used[cid_q[SIW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          sel_c:   state_d = CLOSE;
          sel_l:   state_d = LISTEN_RSP;
          sel_o:   state_d = o_ok ? OPEN_WAIT : OPEN_RSP;
          default: state_d = IDLE;
        endcase
      end
      LISTEN_RSP: begin
        if (m_axis_listen_port_status_tready) state_d = IDLE;
      end
      OPEN_WAIT: begin
        if (wait_q == 32'(OPEN_LATENCY - 1)) state_d = OPEN_RSP;
      end
      OPEN_RSP: begin
        if (m_axis_open_status_tready) state_d = IDLE;
      end
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Close beats listen beats open; only the winner sees ready.
  always_comb begin
    sel_c = 1'b0;
    sel_l = 1'b0;
    sel_o = 1'b0;
    if (state_q == IDLE) begin
      sel_c = s_axis_close_connection_tvalid;
      sel_l = !s_axis_close_connection_tvalid && s_axis_listen_port_tvalid;
      sel_o = !s_axis_close_connection_tvalid && !s_axis_listen_port_tvalid &&
              s_axis_open_connection_tvalid;
    end
  end

  assign s_axis_close_connection_tready   = sel_c;
  assign s_axis_listen_port_tready        = sel_l;
  assign s_axis_open_connection_tready    = sel_o;
  assign m_axis_listen_port_status_tvalid = (state_q == LISTEN_RSP);
  assign m_axis_listen_port_status_tdata  = lsts_q;
  assign m_axis_open_status_tvalid        = (state_q == OPEN_RSP);
  assign m_axis_open_status_tdata         = osts_q;
  assign active_sessions                  = act_q;
  assign listen_count                     = lcnt_q;
  assign close_err                        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LISTEN; i++) ltab[i] <= '0;
      for (int i = 0; i < MAX_SESSIONS; i++) stab[i] <= '0;
      lsts_q <= '0;
      osts_q <= '0;
      cid_q  <= '0;
      wait_q <= '0;
      act_q  <= '0;
      lcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (sel_l) begin
        lsts_q <= {7'd0, l_ok};
        if (l_ins) begin
          ltab[l_idx] <= '{valid: 1'b1, port: lp};
          lcnt_q      <= lcnt_q + 1'b1;
        end
      end
      if (sel_o) begin
        wait_q <= '0;
        if (o_ok) begin
          stab[s_idx] <= '{valid: 1'b1, ip: o_ip, port: o_port};
          act_q       <= act_q + 1'b1;
          osts_q      <= {7'd0, 1'b1, SID_W'(s_idx)};
        end else begin
          osts_q <= '0;
        end
      end
      if (state_q == OPEN_WAIT) wait_q <= wait_q + 1'b1;
      if (sel_c) cid_q <= s_axis_close_connection_tdata;
      if (state_q == CLOSE) begin
        if (c_ok) begin
          stab[cid_q[SIW-1:0]] <= '0;
          act_q                <= act_q - 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

`ifdef TCP_RESP_STATS_EN
  logic [STAT_W-1:0] ok_q, fail_q, cls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q   <= '0;
      fail_q <= '0;
      cls_q  <= '0;
    end else begin
      if (state_q == OPEN_RSP && m_axis_open_status_tready) begin
        if (osts_q[16]) ok_q <= ok_q + 1'b1;
        else            fail_q <= fail_q + 1'b1;
      end
      if (state_q == CLOSE && c_ok) cls_q <= cls_q + 1'b1;
    end
  end

  assign stat_reg = {cls_q, fail_q, ok_q};
`else
  assign stat_reg = '0;
`endif

endmodule
